// File: rtl/axi4_slave_mem.sv
// rtl/axi4_slave_mem.sv - AXI4 INCR-burst memory slave with word-addressed RAM and SLVERR checking
module axi4_slave_mem #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    input  logic                  WLAST,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);
    localparam int IDX_W = $clog2(MEMORY_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // A burst is rejected as a whole: bad size, runs past the RAM, or crosses a 4KB page.
    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [7:0] len,
                                       input logic [2:0] size);
        logic [31:0] last_word;
        logic [31:0] end_off;
        last_word = 32'(addr >> 2) + 32'(len);
        end_off   = 32'(addr[11:0]) + ((32'(len) + 32'd1) << 2);
        return (size != 3'b010) || (last_word >= 32'(MEMORY_DEPTH)) || (end_off > 32'd4096);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];

    wstate_t         r_wstate, w_wstate_nxt;
    logic            r_awready, r_wready, r_bvalid;
    logic [1:0]      r_bresp;
    logic [IDX_W-1:0] r_widx;
    logic [7:0]      r_awlen, r_wcnt;
    logic            r_werr, r_wlast_err;
    logic            w_aw_hs, w_w_hs, w_b_hs, w_w_last, w_we;

    assign w_aw_hs  = AWVALID & r_awready;
    assign w_w_hs   = WVALID & r_wready;
    assign w_b_hs   = r_bvalid & BREADY;
    assign w_w_last = (r_wcnt == r_awlen);
    assign w_we     = w_w_hs & ~r_werr;

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs)             w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_w_last)  w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs)              w_wstate_nxt = W_IDLE;
            default:                          w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= 2'b00;
            r_widx      <= '0;
            r_awlen     <= 8'd0;
            r_wcnt      <= 8'd0;
            r_werr      <= 1'b0;
            r_wlast_err <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b1;
                        r_widx      <= AWADDR[IDX_W+1:2];
                        r_awlen     <= AWLEN;
                        r_wcnt      <= 8'd0;
                        r_werr      <= burst_err(AWADDR, AWLEN, AWSIZE);
                        r_wlast_err <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_widx <= r_widx + IDX_W'(1);
                        r_wcnt <= r_wcnt + 8'd1;
                        if (WLAST != w_w_last)
                            r_wlast_err <= 1'b1;
                        // The beat counter, not WLAST, decides where the burst ends.
                        if (w_w_last) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || r_wlast_err || (WLAST != w_w_last)) ? 2'b10 : 2'b00;
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= 2'b00;
                        r_awready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_we)
            r_mem[r_widx] <= WDATA;
    end

    rstate_t          r_rstate, w_rstate_nxt;
    logic             r_arready, r_rvalid, r_rlast, r_rerr;
    logic [1:0]       r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [IDX_W-1:0] r_ridx;
    logic [7:0]       r_arlen, r_rcnt;
    logic             w_ar_hs, w_r_hs, w_ar_err;

    assign w_ar_hs  = ARVALID & r_arready;
    assign w_r_hs   = r_rvalid & RREADY;
    assign w_ar_err = burst_err(ARADDR, ARLEN, ARSIZE);

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)           w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
            default:                        w_rstate_nxt = R_IDLE;
        endcase
    end

    // RAM is read on the same edge a write may land, so a colliding read sees the old word.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
            r_rerr    <= 1'b0;
            r_ridx    <= '0;
            r_arlen   <= 8'd0;
            r_rcnt    <= 8'd0;
        end else begin
            r_rstate <= w_rstate_nxt;
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rerr    <= w_ar_err;
                        r_rdata   <= w_ar_err ? '0 : r_mem[ARADDR[IDX_W+1:2]];
                        r_rresp   <= w_ar_err ? 2'b10 : 2'b00;
                        r_rlast   <= (ARLEN == 8'd0);
                        r_ridx    <= ARADDR[IDX_W+1:2] + IDX_W'(1);
                        r_arlen   <= ARLEN;
                        r_rcnt    <= 8'd0;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rresp   <= 2'b00;
                            r_rdata   <= '0;
                            r_arready <= 1'b1;
                        end else begin
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rlast <= ((r_rcnt + 8'd1) == r_arlen);
                            r_rdata <= r_rerr ? '0 : r_mem[r_ridx];
                            r_ridx  <= r_ridx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign RLAST   = r_rlast;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb/tb_axi4_slave_mem.sv - directed self-checking bench for axi4_slave_mem
module tb_axi4_slave_mem;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [15:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = 3'd2;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic        WVALID = 1'b0;
    logic        WLAST = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [15:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = 3'd2;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;

    axi4_slave_mem dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] wbuf [16];
    logic [31:0] rdat [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input int gap, input int wlast_at, input int bdelay, output logic [1:0] resp);
        int t;
        logic hs;
        logic [1:0] first;
        AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
        t = 0;
        do begin hs = AWREADY; tick(); t++; end while (!hs && t < 50);
        AWVALID = 1'b0;
        if (!hs) check("aw_timeout", 32'd0, 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            WVALID = 1'b0;
            repeat (gap) tick();
            WDATA = wbuf[i]; WLAST = (i == wlast_at); WVALID = 1'b1;
            t = 0;
            do begin hs = WREADY; tick(); t++; end while (!hs && t < 50);
            if (!hs) check("w_timeout", 32'd0, 32'd1);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        t = 0;
        while (!BVALID && t < 50) begin tick(); t++; end
        first = BRESP;
        repeat (bdelay) begin
            tick();
            check("b_hold_valid", 32'(BVALID), 32'd1);
            check("b_hold_resp", 32'(BRESP), 32'(first));
        end
        BREADY = 1'b1;
        t = 0;
        do begin hs = BVALID; resp = BRESP; tick(); t++; end while (!hs && t < 50);
        BREADY = 1'b0;
        if (!hs) check("b_timeout", 32'd0, 32'd1);
        check("b_cleared", 32'(BVALID), 32'd0);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input int rdelay);
        int t;
        logic hs;
        logic [31:0] d;
        ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARVALID = 1'b1;
        t = 0;
        do begin hs = ARREADY; tick(); t++; end while (!hs && t < 50);
        ARVALID = 1'b0;
        if (!hs) check("ar_timeout", 32'd0, 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!RVALID && t < 50) begin tick(); t++; end
            if (!RVALID) check("r_timeout", 32'd0, 32'd1);
            if (i == 0 && rdelay > 0) begin
                d = RDATA;
                repeat (rdelay) begin
                    tick();
                    check("r_hold_valid", 32'(RVALID), 32'd1);
                    check("r_hold_data", RDATA, d);
                end
            end
            rdat[i] = RDATA; rrsp[i] = RRESP; rlst[i] = RLAST;
            RREADY = 1'b1;
            tick();
            RREADY = 1'b0;
        end
        check("r_done", 32'(RVALID), 32'd0);
    endtask

    logic [1:0] resp;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_arready", 32'(ARREADY), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_wready", 32'(WREADY), 32'd0);
        ARESETn = 1'b1;
        tick();
        check("post_rst_awready", 32'(AWREADY), 32'd1);
        check("post_rst_arready", 32'(ARREADY), 32'd1);

        // single beat write then read
        wbuf[0] = 32'hDEADBEEF;
        do_write(16'h0010, 8'd0, 3'd2, 0, 0, 0, resp);
        check("single_bresp", 32'(resp), 32'd0);
        do_read(16'h0010, 8'd0, 0);
        check("single_rdata", rdat[0], 32'hDEADBEEF);
        check("single_rresp", 32'(rrsp[0]), 32'd0);
        check("single_rlast", 32'(rlst[0]), 32'd1);

        // INCR burst with W gaps and B/R backpressure
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        do_write(16'h0100, 8'd3, 3'd2, 2, 3, 5, resp);
        check("burst_bresp", 32'(resp), 32'd0);
        do_read(16'h0100, 8'd3, 5);
        for (int i = 0; i < 4; i++) begin
            check("burst_rdata", rdat[i], 32'(i + 1));
            check("burst_rresp", 32'(rrsp[i]), 32'd0);
            check("burst_rlast", 32'(rlst[i]), (i == 3) ? 32'd1 : 32'd0);
        end

        // out of range: word 1024 must not alias onto word 0
        wbuf[0] = 32'h0BADF00D;
        do_write(16'h0000, 8'd0, 3'd2, 0, 0, 0, resp);
        check("w0_bresp", 32'(resp), 32'd0);
        wbuf[0] = 32'h12345678;
        do_write(16'h1000, 8'd0, 3'd2, 0, 0, 0, resp);
        check("oor_bresp", 32'(resp), 32'd2);
        do_read(16'h0000, 8'd0, 0);
        check("oor_no_alias", rdat[0], 32'h0BADF00D);
        wbuf[0] = 32'h55AA55AA;
        do_write(16'h0FFC, 8'd0, 3'd2, 0, 0, 0, resp);
        check("top_word_bresp", 32'(resp), 32'd0);
        do_read(16'h0FFC, 8'd1, 0);
        check("oor_r0_data", rdat[0], 32'd0);
        check("oor_r0_resp", 32'(rrsp[0]), 32'd2);
        check("oor_r1_resp", 32'(rrsp[1]), 32'd2);
        check("oor_r1_last", 32'(rlst[1]), 32'd1);
        do_read(16'h0FFC, 8'd0, 0);
        check("top_word_rdata", rdat[0], 32'h55AA55AA);

        // 4KB crossing
        wbuf[0] = 32'hCAFEF00D;
        do_write(16'h0FF8, 8'd0, 3'd2, 0, 0, 0, resp);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hEEEE0000 + 32'(i);
        do_write(16'h0FF8, 8'd3, 3'd2, 0, 3, 0, resp);
        check("cross4k_bresp", 32'(resp), 32'd2);
        do_read(16'h0FF8, 8'd0, 0);
        check("cross4k_unchanged", rdat[0], 32'hCAFEF00D);

        // bad size and early WLAST
        wbuf[0] = 32'h1;
        do_write(16'h0020, 8'd0, 3'd3, 0, 0, 0, resp);
        check("badsize_bresp", 32'(resp), 32'd2);
        wbuf[0] = 32'h2; wbuf[1] = 32'h3;
        do_write(16'h0030, 8'd1, 3'd2, 0, 0, 0, resp);
        check("wlast_mismatch_bresp", 32'(resp), 32'd2);

        // reset during beat 2 of a len-7 read
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(16'h0200, 8'd7, 3'd2, 0, 7, 0, resp);
        check("rst_burst_bresp", 32'(resp), 32'd0);
        ARADDR = 16'h0200; ARLEN = 8'd7; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        RREADY = 1'b1;
        tick();
        tick();
        check("rst_beat2_data", RDATA, 32'hA2);
        ARESETn = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(RVALID), 32'd0);
        RREADY = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
        check("rst_mid_arready", 32'(ARREADY), 32'd1);
        do_read(16'h0200, 8'd1, 0);
        check("rst_mid_keep0", rdat[0], 32'hA0);
        check("rst_mid_keep1", rdat[1], 32'hA1);
        do_read(16'h0010, 8'd0, 0);
        check("rst_mid_keep_old", rdat[0], 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
- AXI4 memory-mapped slave backed by an internal word-addressed RAM; sits behind the AXI4 interface as the target for bus-master testbenches.
- Supports INCR bursts of 1–256 beats on independent write (AW/W/B) and read (AR/R) paths.
- Flags out-of-range and 4KB-crossing bursts with SLVERR.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (beat = 4 bytes).
- ADDR_WIDTH, 16, byte address width.
- MEMORY_DEPTH, 1024, number of DATA_WIDTH words in the RAM.

Ports:
- ACLK in 1: clock, all logic on rising edge.
- ARESETn in 1: asynchronous active-low reset.
- AWADDR in ADDR_WIDTH: write burst start byte address.
- AWLEN in 8: beats-1.
- AWSIZE in 3: must be 3'b010; other values produce SLVERR.
- AWVALID in 1; AWREADY out 1.
- WDATA in DATA_WIDTH; WVALID in 1; WLAST in 1; WREADY out 1.
- BRESP out 2; BVALID out 1; BREADY in 1.
- ARADDR in ADDR_WIDTH; ARLEN in 8; ARSIZE in 3.
- ARVALID in 1; ARREADY out 1.
- RDATA out DATA_WIDTH; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.

Behaviour:
- Reset (async, ARESETn=0): all outputs 0; both FSMs to IDLE; RAM contents not cleared.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY=1 (registered, first cycle after reset release). On AWVALID&AWREADY:
    - Latch address, len and size; beat counter = 0.
    - Compute error = (AWSIZE≠2) | (word index of last beat ≥ MEMORY_DEPTH) | (AWADDR[11:0] + (AWLEN+1)*4 > 4096).
    - AWREADY→0; go W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY beat:
    - Write WDATA to mem[addr>>2] only if no error.
    - addr += 4; counter++.
    - On the beat where counter==len, WREADY→0 and go W_RESP. Completion is determined by the counter; WLAST is ignored for completion.
    - A WLAST/counter mismatch sets BRESP=SLVERR.
  - W_RESP: BVALID=1, BRESP = 2'b10 if error else 2'b00. Holds until BREADY; then BVALID→0, go W_IDLE with AWREADY=1.
- Read FSM R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY=1. On handshake:
    - Latch address, len and size; compute error with the same rule as writes.
    - Go R_DATA; RVALID asserts next cycle (1-cycle latency).
  - R_DATA: RDATA = mem[addr>>2] (0 if error); RRESP per-beat 2'b10 on error else 2'b00; RLAST=1 when counter==len.
    - RVALID, RDATA, RRESP and RLAST stay stable while RREADY=0.
    - On RVALID&RREADY: advance to the next beat (next RVALID the following cycle, back-to-back allowed).
    - After the last beat, RVALID/RLAST→0, go R_IDLE.
- Address low bits [1:0] are ignored (word aligned). Address increments by 4 per beat; no wrap.
- Read and write channels are fully independent and may be active simultaneously.
- Simultaneous read and write to the same word in the same cycle: read returns the old data.
- Reset mid-burst: burst abandoned, no response issued; RAM words already written remain.
- VALID outputs never depend combinationally on READY inputs.
- Protocol properties (checked by the bound assertion module):
  - VALID stays high and payload stays stable until handshake.
  - No X on VALID/READY out of reset.
  - BVALID only after the last W beat.
  - RLAST exactly on beat len.

Test Plan:
- Single write then read: AW 0x0010 len 0, W 0xDEADBEEF → BRESP 00; AR 0x0010 len 0 → RDATA 0xDEADBEEF, RRESP 00, RLAST=1.
- INCR burst: write len 3 at 0x0100 with data 1,2,3,4 → BRESP 00; read len 3 at 0x0100 → 1,2,3,4, RLAST on 4th beat only.
- Backpressure: hold BREADY/RREADY low 5 cycles → BVALID/RVALID and payload stable; WVALID gaps delay beats without data loss.
- Out of range: write at 0x1000 (word 1024) → BRESP 10, no RAM change; read at 0x0FFC len 1 → beat 0 SLVERR, data 0.
- 4KB crossing: AW 0x0FF8 len 3 → BRESP 10, memory at 0x0FF8 unchanged.
- Reset mid-read burst: ARESETn low during beat 2 of a len-7 read → RVALID 0 immediately, ARREADY 1 after release, prior written data intact.
